// File: rtl/riscv_v_alu_sequencer.sv
// riscv_v_alu_sequencer: steps one vector ALU instruction across its LMUL chunks, with a reduction accumulator and writeback handshake
//
// Optional feature macro: RISCV_V_SEQ_PERF_EN adds perf_clr, perf_busy_cycles and perf_stall_cycles.
// Ports:
//   issue_*   instruction offer from vector issue (valid/ready); nchunks==0 is treated as 1
//   flush     abort the current instruction; outstanding operands are drained and discarded
//   opnd_req_*  per-chunk operand fetch requests, at most MAX_OUT outstanding
//   opnd_valid/opnd_ack  operands of the oldest request presented to the ALU, consumed on ack
//   alu_*     registered control bundle, accumulator feedback for reductions, ALU result
//   wb_*      writeback valid/ready handshake, data, chunk index and tag
//   busy      sequencer not idle
module riscv_v_alu_sequencer #(
  parameter int DATA_W     = 128,
  parameter int CTRL_W     = 24,
  parameter int MAX_CHUNKS = 8,
  parameter int CNT_W      = 4,
  parameter int MAX_OUT    = 2,
  parameter int TAG_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [CTRL_W-1:0] issue_ctrl,
  input  logic [CNT_W-1:0]  issue_nchunks,
  input  logic              issue_reduct,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              flush,
  output logic              opnd_req_valid,
  output logic [CNT_W-1:0]  opnd_req_chunk,
  input  logic              opnd_req_ready,
  input  logic              opnd_valid,
  output logic              opnd_ack,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              alu_use_acc,
  output logic [DATA_W-1:0] alu_acc,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  wb_chunk,
  output logic [TAG_W-1:0]  wb_tag,
  output logic              busy
`ifdef RISCV_V_SEQ_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_stall_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_nchunks, r_req_cnt, r_done_cnt, r_outst, w_outst_next;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_acc;
  logic [TAG_W-1:0] r_tag;
  logic r_reduct, w_run, w_last, w_has, w_req_fire, w_fire, w_accept;
  assign w_run = r_state == RUN;
  assign w_last = r_done_cnt == r_nchunks - CNT_W'(1);
  assign w_has = opnd_valid && r_outst != '0;
  assign w_accept = issue_ready && issue_valid;
  assign issue_ready = r_state == IDLE;
  assign busy = !issue_ready;
  assign opnd_req_valid = w_run && !flush && r_req_cnt < r_nchunks && r_outst < CNT_W'(MAX_OUT);
  assign opnd_req_chunk = r_req_cnt;
  assign w_req_fire = opnd_req_valid && opnd_req_ready;
  // non-final reduction passes only feed the accumulator, so they need no writeback slot
  assign w_fire = w_run && !flush && w_has && (wb_ready || (r_reduct && !w_last));
  assign opnd_ack = w_fire || (r_state == DRAIN && w_has);
  assign wb_valid = w_run && !flush && w_has && (!r_reduct || w_last);
  assign w_outst_next = r_outst + CNT_W'(w_req_fire) - CNT_W'(opnd_ack);
  assign alu_ctrl = r_ctrl;
  assign alu_use_acc = w_run && r_reduct && r_done_cnt != '0;
  assign alu_acc = r_acc;
  assign wb_data = alu_result;
  assign wb_chunk = r_reduct ? '0 : r_done_cnt;
  assign wb_tag = r_tag;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = issue_valid ? RUN : IDLE;
      RUN:     w_next = flush ? DRAIN : (w_fire && w_last) ? IDLE : RUN;
      default: w_next = (w_outst_next == '0) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ctrl <= '0;
      r_nchunks <= '0;
      r_reduct <= 1'b0;
      r_tag <= '0;
      r_req_cnt <= '0;
      r_done_cnt <= '0;
      r_outst <= '0;
      r_acc <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ctrl <= issue_ctrl;
        r_nchunks <= (issue_nchunks == '0) ? CNT_W'(1) :
                     (issue_nchunks > CNT_W'(MAX_CHUNKS)) ? CNT_W'(MAX_CHUNKS) : issue_nchunks;
        r_reduct <= issue_reduct;
        r_tag <= issue_tag;
        r_req_cnt <= '0;
        r_done_cnt <= '0;
        r_outst <= '0;
        r_acc <= '0;
      end else begin
        if (w_req_fire) r_req_cnt <= r_req_cnt + CNT_W'(1);
        if (w_fire) r_done_cnt <= r_done_cnt + CNT_W'(1);
        r_outst <= w_outst_next;
        if (w_fire && r_reduct && !w_last) r_acc <= alu_result;
      end
    end
  end
`ifdef RISCV_V_SEQ_PERF_EN
  logic w_stall;
  assign w_stall = w_run && ((wb_valid && !wb_ready) || (!opnd_valid && r_outst != '0));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cycles <= '0;
      perf_stall_cycles <= '0;
    end else if (perf_clr) begin
      perf_busy_cycles <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && !(&perf_busy_cycles)) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (w_stall && !(&perf_stall_cycles)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_riscv_v_alu_sequencer.sv
// tb_riscv_v_alu_sequencer: table-driven and randomized self-checking bench for riscv_v_alu_sequencer
module tb_riscv_v_alu_sequencer;
  logic clk = 1'b0;
  logic rst, issue_valid, issue_ready, issue_reduct, flush, opnd_req_valid, opnd_req_ready;
  logic opnd_valid, opnd_ack, alu_use_acc, wb_valid, wb_ready, busy;
  logic [23:0] issue_ctrl, alu_ctrl;
  logic [3:0] issue_nchunks, opnd_req_chunk, wb_chunk;
  logic [4:0] issue_tag, wb_tag;
  logic [127:0] alu_acc, alu_result, wb_data;
`ifdef RISCV_V_SEQ_PERF_EN
  logic perf_clr;
  logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif
  int checks = 0;
  int failures = 0;

  riscv_v_alu_sequencer dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_ctrl(issue_ctrl), .issue_nchunks(issue_nchunks), .issue_reduct(issue_reduct),
    .issue_tag(issue_tag), .flush(flush), .opnd_req_valid(opnd_req_valid),
    .opnd_req_chunk(opnd_req_chunk), .opnd_req_ready(opnd_req_ready), .opnd_valid(opnd_valid),
    .opnd_ack(opnd_ack), .alu_ctrl(alu_ctrl), .alu_use_acc(alu_use_acc), .alu_acc(alu_acc),
    .alu_result(alu_result), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_chunk(wb_chunk), .wb_tag(wb_tag), .busy(busy)
`ifdef RISCV_V_SEQ_PERF_EN
    , .perf_clr(perf_clr), .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int n; bit red; int tag; bit det;
    int exp_passes; int exp_wbs; int exp_first; int exp_cycles;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_issue_ready"}, issue_ready, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_req_valid"}, opnd_req_valid, 0);
    chk({nm, "_req_chunk"}, opnd_req_chunk, 0);
    chk({nm, "_ack"}, opnd_ack, 0);
    chk({nm, "_alu_ctrl"}, alu_ctrl, 0);
    chk({nm, "_use_acc"}, alu_use_acc, 0);
    chk({nm, "_alu_acc"}, alu_acc, 0);
    chk({nm, "_wb_valid"}, wb_valid, 0);
    chk({nm, "_wb_data"}, wb_data, 0);
    chk({nm, "_wb_chunk"}, wb_chunk, 0);
    chk({nm, "_wb_tag"}, wb_tag, 0);
  endtask

  // Reference: counts of chunks requested and passed; outstanding = requested - passed.
  task automatic run_instr(input vec_t v, output int passes, output int wbs, output int first, output int cycles);
    int n, reqd, passed;
    logic ov;
    logic [127:0] res, acc;
    logic [23:0] ctrl;
    bit last, e_req, e_wbv, e_ack;
    n = (v.n == 0) ? 1 : v.n;
    ctrl = 24'($urandom);
    @(negedge clk);
    issue_valid = 1; issue_ctrl = ctrl; issue_nchunks = v.n[3:0];
    issue_reduct = v.red; issue_tag = v.tag[4:0];
    #1 chk("accept_ready", issue_ready, 1);
    @(posedge clk);
    reqd = 0; passed = 0; ov = 0; res = 0; acc = 0; wbs = 0; first = -1; cycles = 0;
    while (passed < n && cycles < 300) begin
      @(negedge clk);
      cycles++;
      issue_valid = 0;
      issue_ctrl = 24'($urandom);
      if (!ov && reqd > passed && (v.det || $urandom_range(0, 2) != 0)) begin
        ov = 1;
        res = v.det ? 128'((passed + 1) * 10) : {$urandom, $urandom, $urandom, $urandom};
      end
      opnd_valid = ov; alu_result = res;
      opnd_req_ready = v.det || $urandom_range(0, 3) != 0;
      wb_ready = v.det || $urandom_range(0, 2) != 0;
      #1;
      last = passed == n - 1;
      e_req = reqd < n && reqd - passed < 2;
      e_wbv = ov && (!v.red || last);
      e_ack = ov && (wb_ready || (v.red && !last));
      chk("run_busy", busy, 1);
      chk("req_valid", opnd_req_valid, e_req);
      if (e_req) chk("req_chunk", opnd_req_chunk, reqd);
      chk("opnd_ack", opnd_ack, e_ack);
      chk("wb_valid", wb_valid, e_wbv);
      if (e_wbv) begin
        chk("wb_data", wb_data, res);
        chk("wb_chunk", wb_chunk, v.red ? 0 : passed);
      end
      chk("wb_tag", wb_tag, v.tag[4:0]);
      chk("alu_ctrl", alu_ctrl, ctrl);
      chk("use_acc", alu_use_acc, v.red && passed > 0);
      if (v.red && passed > 0) chk("alu_acc", alu_acc, acc);
      if (e_wbv && first < 0) first = cycles;
      if (e_wbv && wb_ready) wbs++;
      @(posedge clk);
      if (e_req && opnd_req_ready) reqd++;
      if (e_ack) begin
        if (v.red && !last) acc = res;
        passed++;
        ov = 0;
      end
    end
    passes = passed;
    @(negedge clk);
    opnd_valid = 0; alu_result = 0;
    #1;
    chk("done_busy", busy, 0);
    chk("done_issue_ready", issue_ready, 1);
  endtask

  initial begin
    int p, w, f, c, acks;
    tbl[0] = '{4, 0, 3, 1, 4, 4, 2, 5};
    tbl[1] = '{3, 1, 9, 1, 3, 1, 4, 4};
    tbl[2] = '{1, 0, 17, 1, 1, 1, 2, 2};
    tbl[3] = '{1, 1, 21, 1, 1, 1, 2, 2};
    tbl[4] = '{0, 0, 30, 1, 1, 1, 2, 2};
    tbl[5] = '{8, 0, 5, 0, 8, 8, -1, -1};
    tbl[6] = '{8, 1, 12, 0, 8, 1, -1, -1};
    tbl[7] = '{5, 0, 31, 0, 5, 5, -1, -1};
    rst = 1; issue_valid = 0; issue_ctrl = 0; issue_nchunks = 0; issue_reduct = 0; issue_tag = 0;
    flush = 0; opnd_req_ready = 0; opnd_valid = 0; alu_result = 0; wb_ready = 0;
`ifdef RISCV_V_SEQ_PERF_EN
    perf_clr = 0;
`endif
    @(negedge clk); #1 chk_idle_outs("reset");
    @(negedge clk); rst = 0;

    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 8; i++) begin
        run_instr(tbl[i], p, w, f, c);
        chk($sformatf("v%0d_passes", i), p, tbl[i].exp_passes);
        chk($sformatf("v%0d_wbs", i), w, tbl[i].exp_wbs);
        if (tbl[i].det) begin
          chk($sformatf("v%0d_first_wb", i), f, tbl[i].exp_first);
          chk($sformatf("v%0d_cycles", i), c, tbl[i].exp_cycles);
        end
      end

    // flush in IDLE is ignored
    @(negedge clk); flush = 1;
    @(negedge clk); #1 chk("idle_flush_busy", busy, 0);
    flush = 0;

    // flush with two requests outstanding: drain both, never write back
    @(negedge clk);
    issue_valid = 1; issue_nchunks = 8; issue_reduct = 0; issue_tag = 7;
    opnd_req_ready = 1; opnd_valid = 0; wb_ready = 1;
    @(negedge clk); issue_valid = 0;
    @(negedge clk);
    @(negedge clk); #1 chk("flush_req_capped", opnd_req_valid, 0);
    flush = 1;
    #1 chk("flush_wb_valid", wb_valid, 0);
    chk("flush_req_valid", opnd_req_valid, 0);
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); flush = 0; opnd_valid = 1;
      #1;
      if (!busy) break;
      chk("drain_wb_valid", wb_valid, 0);
      chk("drain_req_valid", opnd_req_valid, 0);
      if (opnd_ack) acks++;
    end
    opnd_valid = 0;
    #1 chk("drain_acks", acks, 2);
    chk("drain_issue_ready", issue_ready, 1);

    // reset in RUN with one request outstanding and a live accumulator
    @(negedge clk);
    issue_valid = 1; issue_nchunks = 4; issue_reduct = 1; issue_tag = 11; issue_ctrl = 24'h5a5a5a;
    opnd_req_ready = 1; opnd_valid = 0;
    @(negedge clk); issue_valid = 0;
    @(negedge clk); opnd_valid = 1; alu_result = 5;
    @(negedge clk); opnd_valid = 0; alu_result = 0; rst = 1;
    #1 chk_idle_outs("midrun_rst");
    @(negedge clk); rst = 0;
    run_instr(tbl[2], p, w, f, c);
    chk("post_rst_wbs", w, 1);
    chk("post_rst_first", f, 2);

`ifdef RISCV_V_SEQ_PERF_EN
    @(negedge clk); perf_clr = 1;
    @(negedge clk); perf_clr = 0;
    #1 chk("perf_clr_busy", perf_busy_cycles, 0);
    chk("perf_clr_stall", perf_stall_cycles, 0);
    run_instr(tbl[0], p, w, f, c);
    chk("perf_busy", perf_busy_cycles, 5);
    chk("perf_stall", perf_stall_cycles, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_v_alu_sequencer.md
Name: riscv_v_alu_sequencer

Overview:
Sequences one vector arithmetic instruction across multiple datapath-width chunks (LMUL groups) through the arithmetic ALU. The sequencer:
- latches the ALU control bundle;
- issues per-chunk operand-fetch requests with a bounded number outstanding;
- drives the ALU once per chunk and hands results to writeback with a valid/ready handshake.

For reductions it holds the running partial result in an accumulator, feeds it back to the ALU, and writes back only the final chunk. It sits between the vector issue stage and the arithmetic ALU / writeback port.

Parameters:
- DATA_W, 128, ALU data width in bits (one chunk)
- CTRL_W, 24, width of packed ALU control bundle (is_add, is_sub, osize vectors, ...)
- MAX_CHUNKS, 8, maximum chunks per instruction (LMUL=8)
- CNT_W, 4, chunk count/index width, holds 0..MAX_CHUNKS
- MAX_OUT, 2, maximum outstanding operand requests
- TAG_W, 5, instruction tag width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  instruction offered
- issue_ready  out  1  sequencer accepts instruction
- issue_ctrl  in  CTRL_W  ALU control bundle
- issue_nchunks  in  CNT_W  chunk count, legal 1..MAX_CHUNKS
- issue_reduct  in  1  instruction is a reduction
- issue_tag  in  TAG_W  instruction tag
- flush  in  1  abort current instruction
- opnd_req_valid  out  1  operand fetch request
- opnd_req_chunk  out  CNT_W  chunk index requested
- opnd_req_ready  in  1  fetch request accepted
- opnd_valid  in  1  operands of oldest outstanding request present on ALU srca/srcb; held until acked
- opnd_ack  out  1  operands consumed this cycle
- alu_ctrl  out  CTRL_W  registered control bundle to ALU
- alu_use_acc  out  1  ALU takes srcb from accumulator
- alu_acc  out  DATA_W  accumulator value
- alu_result  in  DATA_W  ALU combinational result
- wb_valid  out  1  writeback data valid
- wb_ready  in  1  writeback accepts
- wb_data  out  DATA_W  writeback data (= alu_result)
- wb_chunk  out  CNT_W  destination chunk index
- wb_tag  out  TAG_W  instruction tag
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock clk; rst is asynchronous, active-high. Reset puts state in IDLE and clears all counters, alu_ctrl, alu_acc, wb_tag. All outputs read 0 after reset except issue_ready, which is 1.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - issue_ready=1.
  - issue_valid latches ctrl/nchunks/reduct/tag and clears req_cnt, done_cnt, outst; next state RUN.
  - First request can appear the cycle after accept.
- RUN, operand requests:
  - opnd_req_valid = (req_cnt < nchunks) && (outst < MAX_OUT).
  - opnd_req_chunk = req_cnt.
  - Request fire = valid && opnd_req_ready; it increments req_cnt and outst.
- RUN, pass fire:
  - fire = opnd_valid && (outst > 0) && (wb_ready || (reduct && !last)), where last = (done_cnt == nchunks-1).
  - On fire: opnd_ack=1, done_cnt++, outst--.
  - A simultaneous request fire and pass fire leaves outst unchanged.
- Writeback:
  - wb_valid = RUN && opnd_valid && (outst > 0) && (!reduct || last).
  - wb_chunk = done_cnt for non-reductions, 0 for reductions.
- Reduction accumulator:
  - alu_use_acc = reduct && done_cnt != 0.
  - On a non-last reduct fire, alu_acc <= alu_result.
  - A single-chunk reduction writes back on its first pass with alu_use_acc=0.
- Completion: the fire with last=1 returns to IDLE. There is no back-to-back issue, so there is at least one IDLE cycle between instructions.
- wb stall: with wb_ready=0 on a writeback pass, nothing advances, opnd_ack=0 and the accumulator holds. Requests may still issue up to MAX_OUT.
- Flush:
  - In RUN: go to DRAIN, wb_valid forced 0, no new requests.
  - In DRAIN: opnd_ack=opnd_valid while outst>0, decrementing outst, with nothing written back. Go to IDLE when outst==0, or at once if outst was already 0.
  - flush in IDLE is ignored.
- Illegal input: issue_nchunks==0 is treated as 1.
- Latency: single-chunk instruction with operands returned the cycle after the request gives wb_valid 2 cycles after issue accept.

Optional Feature:
RISCV_V_SEQ_PERF_EN.
- Defined: adds outputs perf_busy_cycles (32) and perf_stall_cycles (32), plus perf_clr (in, 1). The two counters:
  - perf_busy_cycles increments every cycle state != IDLE;
  - perf_stall_cycles increments on RUN cycles where wb_valid && !wb_ready, or where opnd_valid==0 with outst>0.
- Both counters saturate at all-ones and are cleared by rst or perf_clr.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Issue add, nchunks=4, opnd_valid one cycle after each request, wb_ready=1 -> wb_valid on 4 consecutive cycles, wb_chunk 0,1,2,3, tag echoed, back to IDLE; outst never exceeds 2.
2. Reduction, nchunks=3, alu_result 10, 20, 30 -> alu_use_acc 0, 1, 1; alu_acc 10, then 20; single wb_valid with wb_data=30, wb_chunk=0.
3. nchunks=2, wb_ready low 5 cycles on chunk 0 -> wb_valid held, opnd_ack=0, wb_data stable, no chunk skipped; chunk 1 follows release.
4. Flush with outst=2 mid nchunks=8 -> wb_valid never asserted again, two opnd_acks in DRAIN, then IDLE and issue_ready=1.
5. Assert rst during RUN with outst=1 -> immediate IDLE, all outputs 0 except issue_ready=1; a new 1-chunk issue completes normally.
6. With RISCV_V_SEQ_PERF_EN, scenario 3 -> perf_stall_cycles==5, perf_busy_cycles equals the number of non-IDLE cycles; perf_clr zeroes both.
